// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: programmable N_IN-input Boolean function unit.
// A serially loaded truth table drives a registered evaluation output and a
// sweep engine that streams every minterm in index order.
// Optional feature macro: LUT_SWEEP_ONES_EN (true-minterm counter on o_ones_cnt).
// When the macro is undefined, o_ones_cnt is tied to zero.
module lut_sweep_eval #(
    parameter int N_IN = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load_en,
    input  logic            i_load_bit,
    output logic            o_cfg_ok,
    input  logic [N_IN-1:0] i_sel,
    output logic            o_f,
    input  logic            i_sweep_start,
    output logic            o_sweep_busy,
    output logic            o_sweep_valid,
    output logic [N_IN-1:0] o_sweep_idx,
    output logic            o_sweep_out,
    output logic            o_sweep_done,
    output logic [N_IN:0]   o_ones_cnt
);

    localparam int DEPTH = 1 << N_IN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    logic [DEPTH-1:0] r_tt;
    logic [N_IN-1:0]  r_lcnt;
    logic             r_cfg_ok;
    logic             r_f;
    logic [1:0]       r_state;
    logic [N_IN-1:0]  r_cnt;
    logic             r_busy;
    logic             r_valid;
    logic [N_IN-1:0]  r_idx;
    logic             r_out;
    logic             r_done;

    // Loads and starts are only honoured while the engine is idle, which
    // freezes the table for the whole sweep. A load wins over a start.
    logic w_idle;
    logic w_load_acc;
    logic w_start_acc;

    assign w_idle      = (r_state == S_IDLE);
    assign w_load_acc  = w_idle & i_load_en;
    assign w_start_acc = w_idle & i_sweep_start & ~i_load_en;

    // Truth-table shift register, load counter and frame-complete flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tt     <= {DEPTH{1'b0}};
            r_lcnt   <= {N_IN{1'b0}};
            r_cfg_ok <= 1'b0;
        end else if (w_load_acc) begin
            r_tt     <= {r_tt[DEPTH-2:0], i_load_bit};
            r_lcnt   <= r_lcnt + IDX_ONE;
            r_cfg_ok <= (r_lcnt == IDX_LAST);
        end else begin
            r_tt     <= r_tt;
            r_lcnt   <= r_lcnt;
            r_cfg_ok <= r_cfg_ok;
        end
    end

    // Registered evaluation; uses the table as it stood before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_f <= 1'b0;
        end else begin
            r_f <= r_tt[i_sel];
        end
    end

    // Sweep engine: IDLE -> RUN (DEPTH minterms) -> DONE (one cycle) -> IDLE.
    // Busy stays high through the first IDLE cycle after DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {N_IN{1'b0}};
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= {N_IN{1'b0}};
            r_out   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    if (w_start_acc) begin
                        r_state <= S_RUN;
                        r_cnt   <= {N_IN{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_valid <= 1'b1;
                    r_idx   <= r_cnt;
                    r_out   <= r_tt[r_cnt];
                    r_cnt   <= r_cnt + IDX_ONE;
                    if (r_cnt == IDX_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LUT_SWEEP_ONES_EN
    localparam logic [N_IN:0] CNT_ONE = {{N_IN{1'b0}}, 1'b1};

    logic [N_IN:0] r_ones;

    // Count true minterms as they are reported; cleared by an accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ones <= {(N_IN+1){1'b0}};
        end else if (w_start_acc) begin
            r_ones <= {(N_IN+1){1'b0}};
        end else if (r_valid && r_out) begin
            r_ones <= r_ones + CNT_ONE;
        end else begin
            r_ones <= r_ones;
        end
    end

    assign o_ones_cnt = r_ones;
`else
    assign o_ones_cnt = {(N_IN+1){1'b0}};
`endif

    assign o_cfg_ok      = r_cfg_ok;
    assign o_f           = r_f;
    assign o_sweep_busy  = r_busy;
    assign o_sweep_valid = r_valid;
    assign o_sweep_idx   = r_idx;
    assign o_sweep_out   = r_out;
    assign o_sweep_done  = r_done;

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval (N_IN = 4).
module tb_lut_sweep_eval;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic       load_bit;
    logic       cfg_ok;
    logic [3:0] sel;
    logic       f;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_valid;
    logic [3:0] sweep_idx;
    logic       sweep_out;
    logic       sweep_done;
    logic [4:0] ones_cnt;

    lut_sweep_eval #(.N_IN(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load_en     (load_en),
        .i_load_bit    (load_bit),
        .o_cfg_ok      (cfg_ok),
        .i_sel         (sel),
        .o_f           (f),
        .i_sweep_start (sweep_start),
        .o_sweep_busy  (sweep_busy),
        .o_sweep_valid (sweep_valid),
        .o_sweep_idx   (sweep_idx),
        .o_sweep_out   (sweep_out),
        .o_sweep_done  (sweep_done),
        .o_ones_cnt    (ones_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic       exp_f;
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic       out;
    } sb_t;

    vec_t       vecs[16];
    logic       fq[$];
    sb_t        sq[$];
    logic [15:0] m_tt;
    logic [15:0] pat;
    int         total;
    int         bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " f"}, {31'd0, f}, 32'd0);
        check({tag, " cfg_ok"}, {31'd0, cfg_ok}, 32'd0);
        check({tag, " busy"}, {31'd0, sweep_busy}, 32'd0);
        check({tag, " valid"}, {31'd0, sweep_valid}, 32'd0);
        check({tag, " idx"}, {28'd0, sweep_idx}, 32'd0);
        check({tag, " out"}, {31'd0, sweep_out}, 32'd0);
        check({tag, " done"}, {31'd0, sweep_done}, 32'd0);
        check({tag, " ones"}, {27'd0, ones_cnt}, 32'd0);
    endtask

    task automatic load_one(input logic b);
        load_en  = 1'b1;
        load_bit = b;
        step();
        load_en  = 1'b0;
        m_tt     = {m_tt[14:0], b};
    endtask

    // Evaluate every index (scrambled order) against the bench model.
    task automatic eval_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            sel = 4'((i * 7) % 16);
            fq.push_back(m_tt[sel]);
            step();
            if (fq.size() == 0) begin
                check({tag, " f queue"}, 32'd0, 32'd1);
            end else begin
                check({tag, " f"}, {31'd0, f}, {31'd0, fq.pop_front()});
            end
        end
    endtask

    // One full sweep; optionally pokes load/start mid-sweep, which must be ignored.
    task automatic run_sweep(input string tag, input bit disturb);
        logic [4:0] exp_ones;
`ifdef LUT_SWEEP_ONES_EN
        exp_ones = 5'($countones(m_tt));
`else
        exp_ones = 5'd0;
`endif
        for (int i = 0; i < 16; i++) begin
            sq.push_back('{idx: 4'(i), out: m_tt[i]});
        end
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check({tag, " busy@T"}, {31'd0, sweep_busy}, 32'd1);
        check({tag, " valid@T"}, {31'd0, sweep_valid}, 32'd0);
        for (int k = 1; k <= 18; k++) begin
            if (disturb && k == 3) begin
                load_en     = 1'b1;
                load_bit    = 1'b1;
                sweep_start = 1'b1;
            end
            if (k == 6) begin
                load_en     = 1'b0;
                sweep_start = 1'b0;
            end
            step();
            check({tag, " valid"}, {31'd0, sweep_valid}, {31'd0, (k >= 1 && k <= 16)});
            check({tag, " done"}, {31'd0, sweep_done}, {31'd0, (k == 17)});
            check({tag, " busy"}, {31'd0, sweep_busy}, {31'd0, (k <= 17)});
            if (sweep_valid) begin
                if (sq.size() == 0) begin
                    check({tag, " sweep queue"}, 32'd0, 32'd1);
                end else begin
                    sb_t e;
                    e = sq.pop_front();
                    check({tag, " idx"}, {28'd0, sweep_idx}, {28'd0, e.idx});
                    check({tag, " out"}, {31'd0, sweep_out}, {31'd0, e.out});
                end
            end
            if (k == 17) begin
                check({tag, " ones"}, {27'd0, ones_cnt}, {27'd0, exp_ones});
            end
        end
        check({tag, " leftover"}, sq.size(), 32'd0);
        sq.delete();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        pat         = 16'hA5C3;
        m_tt        = 16'h0000;
        rst         = 1'b1;
        load_en     = 1'b0;
        load_bit    = 1'b0;
        sel         = 4'd0;
        sweep_start = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].sel   = 4'((i * 5 + 3) % 16);
            vecs[i].exp_f = pat[(i * 5 + 3) % 16];
        end

        // Reset and idle.
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_zero("idle");
        end

        // Load 0xA5C3 MSB first.
        for (int i = 0; i < 16; i++) begin
            load_one(pat[15 - i]);
            check("cfg_ok during load", {31'd0, cfg_ok}, {31'd0, (i == 15)});
        end

        // Table-driven evaluation through the f scoreboard.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                sel = vecs[i].sel;
                fq.push_back(vecs[i].exp_f);
            end
            step();
            if (i < 16) begin
                if (fq.size() == 0) begin
                    check("tbl f queue", 32'd0, 32'd1);
                end else begin
                    check("tbl f", {31'd0, f}, {31'd0, fq.pop_front()});
                end
            end
        end

        // 17th load clears cfg_ok; refill so the table is 0xA5C3 again.
        load_one(pat[15]);
        check("cfg_ok after 17th", {31'd0, cfg_ok}, 32'd0);
        for (int i = 14; i >= 0; i--) begin
            load_one(pat[i]);
        end
        check("cfg_ok refill", {31'd0, cfg_ok}, 32'd1);
        check("model tt", {16'd0, m_tt}, {16'd0, pat});

        // Clean sweep, then a sweep disturbed by load/start attempts.
        run_sweep("sweep1", 1'b0);
        run_sweep("sweep2", 1'b1);
        eval_all("frozen");
        check("cfg_ok kept", {31'd0, cfg_ok}, 32'd1);

        // Start and load together in IDLE: the load wins.
        load_en     = 1'b1;
        load_bit    = 1'b0;
        sweep_start = 1'b1;
        step();
        load_en     = 1'b0;
        sweep_start = 1'b0;
        m_tt        = {m_tt[14:0], 1'b0};
        check("combo busy", {31'd0, sweep_busy}, 32'd0);
        check("combo cfg_ok", {31'd0, cfg_ok}, 32'd0);
        step();
        check("combo busy+1", {31'd0, sweep_busy}, 32'd0);
        check("combo valid+1", {31'd0, sweep_valid}, 32'd0);
        eval_all("combo");

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check("mid busy", {31'd0, sweep_busy}, 32'd1);
        rst = 1'b1;
        sel = 4'd0;
        step();
        rst  = 1'b0;
        m_tt = 16'h0000;
        chk_zero("midrst");
        eval_all("cleared");
        run_sweep("sweep3", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
